// File: rtl/rc_add_sub_pkg.sv
// Shared constants for the ripple-carry adder/subtractor: default width,
// reset values and the signed-overflow helper.
package rc_add_sub_pkg;

  localparam int   WIDTH_DEF = 32;
  localparam logic RST_BIT   = 1'b0;
  localparam int   PRIM_W    = 32;

  // Overflow occurs when the carries into and out of the sign bit disagree.
  function automatic logic ovf_f(input logic c_msb, input logic c_prev);
    return c_msb ^ c_prev;
  endfunction

endpackage

// File: rtl/INV32_1x1.sv
// Library primitive: 32 parallel single-input inverters.
module INV32_1x1 (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = ~a;
endmodule

// File: rtl/MUX1_2x1.sv
// Library primitive: single-bit 2:1 multiplexer (sel=1 chooses d1).
module MUX1_2x1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/full_adder.sv
// One ripple-carry stage: sum and carry-out from a, b and carry-in.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/rc_add_sub_32.sv
// Registered ripple-carry adder/subtractor: Y = A+B (SnA=0) or A-B (SnA=1),
// with carry-out (no-borrow on subtract), signed overflow and a one-cycle VALID.
module rc_add_sub_32
  import rc_add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             V,
  output logic             VALID
);

  localparam int NCHUNK = (WIDTH + PRIM_W - 1) / PRIM_W;
  localparam int PW     = NCHUNK * PRIM_W;

  logic [PW-1:0]    b_pad_p0;
  logic [PW-1:0]    b_inv_pad_p0;
  logic [WIDTH-1:0] b_cond_p0;
  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH:0]   carry_p0;

  assign b_pad_p0    = PW'(B);
  assign carry_p0[0] = SnA;

  // Inverter primitives are fixed-width, so the operand is padded to whole chunks.
  for (genvar k = 0; k < NCHUNK; k++) begin : g_inv
    INV32_1x1 u_inv (
      .a (b_pad_p0[k*PRIM_W +: PRIM_W]),
      .y (b_inv_pad_p0[k*PRIM_W +: PRIM_W])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    MUX1_2x1 u_mux (
      .d0  (B[i]),
      .d1  (b_inv_pad_p0[i]),
      .sel (SnA),
      .y   (b_cond_p0[i])
    );

    full_adder u_fa (
      .a  (A[i]),
      .b  (b_cond_p0[i]),
      .ci (carry_p0[i]),
      .s  (sum_p0[i]),
      .co (carry_p0[i+1])
    );
  end

  // ---- stage p0 -> output register bank ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Y     <= {WIDTH{RST_BIT}};
      CO    <= RST_BIT;
      V     <= RST_BIT;
      VALID <= RST_BIT;
    end else begin
      VALID <= EN;
      if (EN) begin
        Y  <= sum_p0;
        CO <= carry_p0[WIDTH];
        V  <= ovf_f(carry_p0[WIDTH], carry_p0[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_rc_add_sub_32.sv
// Scoreboard bench for rc_add_sub_32: the driver pushes the expected output
// of every clock edge, a negedge monitor pops and compares it.
module tb_rc_add_sub_32;

  logic        CLK = 1'b0;
  logic        RESET, EN, SnA;
  logic [31:0] A, B, Y;
  logic        CO, V, VALID;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_y_q[$];
  logic        exp_co_q[$];
  logic        exp_v_q[$];
  logic        exp_vld_q[$];
  string       name_q[$];

  logic [31:0] m_y;
  logic        m_co, m_v;

  rc_add_sub_32 #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (EN),
    .SnA   (SnA),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .CO    (CO),
    .V     (V),
    .VALID (VALID)
  );

  always #5 CLK = ~CLK;

  // Reference result built from unsigned 33-bit arithmetic and operand signs.
  task automatic model(input logic sna, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] y, output logic co, output logic v);
    logic [32:0] s;
    if (sna) s = {1'b0, a} - {1'b0, b};
    else     s = {1'b0, a} + {1'b0, b};
    y  = s[31:0];
    co = sna ? (a >= b) : s[32];
    if (sna) v = (a[31] != b[31]) && (y[31] != a[31]);
    else     v = (a[31] == b[31]) && (y[31] != a[31]);
  endtask

  task automatic drive(input string nm, input logic rst, input logic en, input logic sna,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    logic co, v;
    RESET = rst; EN = en; SnA = sna; A = a; B = b;
    @(posedge CLK);
    if (rst) begin
      m_y = 32'h0; m_co = 1'b0; m_v = 1'b0;
    end else if (en) begin
      model(sna, a, b, y, co, v);
      m_y = y; m_co = co; m_v = v;
    end
    exp_y_q.push_back(m_y);
    exp_co_q.push_back(m_co);
    exp_v_q.push_back(m_v);
    exp_vld_q.push_back(!rst && en);
    name_q.push_back(nm);
    #1;
    // Scramble inputs between edges; they must have no effect.
    A = $urandom; B = $urandom; SnA = $urandom_range(0, 1);
  endtask

  always @(negedge CLK) begin
    if (exp_y_q.size() > 0) begin
      logic [31:0] ey;
      logic eco, ev, evld;
      string nm;
      ey = exp_y_q.pop_front(); eco = exp_co_q.pop_front();
      ev = exp_v_q.pop_front(); evld = exp_vld_q.pop_front();
      nm = name_q.pop_front();
      compared++;
      if (Y !== ey || CO !== eco || V !== ev || VALID !== evld) begin
        mismatched++;
        $display("FAIL %s: got Y=%h CO=%b V=%b VALID=%b, want Y=%h CO=%b V=%b VALID=%b",
                 nm, Y, CO, V, VALID, ey, eco, ev, evld);
      end
    end
  end

  initial begin
    m_y = 32'h0; m_co = 1'b0; m_v = 1'b0;
    RESET = 1'b1; EN = 1'b0; SnA = 1'b0; A = '0; B = '0;
    @(posedge CLK); #1;

    drive("reset_with_en", 1, 1, 0, 32'd5, 32'd3);
    drive("add_5_3",       0, 1, 0, 32'h5, 32'h3);
    drive("hold_1",        0, 0, 0, 32'd9, 32'd9);
    drive("hold_2",        0, 0, 1, 32'd9, 32'd9);
    drive("hold_3",        0, 0, 0, 32'd9, 32'd9);
    drive("add_wrap",      0, 1, 0, 32'hFFFFFFFF, 32'h1);
    drive("sub_5_3",       0, 1, 1, 32'd5, 32'd3);
    drive("sub_3_5",       0, 1, 1, 32'd3, 32'd5);
    drive("add_ovf",       0, 1, 0, 32'h7FFFFFFF, 32'h1);
    drive("sub_ovf",       0, 1, 1, 32'h80000000, 32'h1);
    drive("sub_equal",     0, 1, 1, 32'h12345678, 32'h12345678);
    drive("add_neg_ovf",   0, 1, 0, 32'h80000000, 32'h80000000);
    drive("inflight",      0, 1, 0, 32'h10, 32'h20);
    drive("mid_reset",     1, 1, 0, 32'h11, 32'h22);
    drive("after_reset",   0, 1, 0, 32'h11, 32'h22);
    drive("idle",          0, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 10000; i++)
      drive("random", 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            $urandom, $urandom);

    RESET = 1'b0; EN = 1'b0;
    repeat (2) @(posedge CLK);
    compared++;
    if (exp_y_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, want 0", exp_y_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rc_add_sub_32.md
RC_ADD_SUB_32 -- requirements
Module: rc_add_sub_32

Interface
REQ-001 SHALL have one parameter: WIDTH, default 32, operand/result width; all requirements below are stated for WIDTH=32.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: CLK  input  1  rising-edge clock.
REQ-004 SHALL have port: RESET  input  1  synchronous active-high reset.
REQ-005 SHALL have port: EN  input  1  capture enable; when 1, the operation is registered at the next CLK edge.
REQ-006 SHALL have port: SnA  input  1  operation select; 0 = add (A+B), 1 = subtract (A-B).
REQ-007 SHALL have port: A  input  32  first operand.
REQ-008 SHALL have port: B  input  32  second operand.
REQ-009 SHALL have port: Y  output  32  registered result.
REQ-010 SHALL have port: CO  output  1  registered carry-out of the MSB full adder.
REQ-011 SHALL have port: V  output  1  registered two's-complement signed overflow.
REQ-012 SHALL have port: VALID  output  1  high for exactly one cycle after each captured operation.

Function
REQ-013 SHALL condition the B operand to B when SnA=0 and to bitwise ~B when SnA=1 (32 inverters plus a per-bit 2:1 mux), and drive carry-in c[0]=SnA.
REQ-014 SHALL compute the sum with a 32-stage ripple-carry chain: s[i]=a^b'^c[i], c[i+1]=a&b' | c[i]&(a^b'); CO=c[32].
REQ-015 SHALL compute V = c[32] XOR c[31].
REQ-016 SHALL wrap results modulo 2^32, with no saturation.
REQ-017 SHALL give CO, on subtract, the meaning of no-borrow: CO=1 iff A>=B unsigned.
REQ-018 SHALL have a latency of 1 cycle: when EN=1 at edge k, Y/CO/V reflect the A, B and SnA values sampled at edge k, and VALID=1 after edge k.
REQ-019 SHALL hold Y, CO and V at their last values when EN=0, and set VALID=0 on that edge.
REQ-020 SHALL handle back-to-back EN=1 cycles: every cycle produces a new result and VALID stays 1.
REQ-021 SHALL treat inputs that change between edges as having no effect; only values sampled at the edge matter.

Reset
REQ-022 SHALL set Y=0x00000000, CO=0, V=0 and VALID=0 at the CLK edge where RESET=1.
REQ-023 SHALL give RESET priority over EN when both are high, so no capture occurs.
REQ-024 SHALL, on reset mid-stream, discard the in-flight operation; the first result appears one edge after RESET deasserts with EN=1.

Structure
REQ-025 SHALL keep the WIDTH default and reset-value constants in a shared package, rc_add_sub_pkg; no typedefs are required.
REQ-026 SHALL use one natural sub-module, full_adder (inputs a, b, ci; outputs s, co), instantiated 32 times via generate.
REQ-027 SHALL build B-operand conditioning from the existing INV32_1x1 and MUX1_2x1 primitives, and SHALL use the output register bank as the only sequential logic.

Verification
REQ-028 SHALL verify reset: RESET=1, EN=1, A=5, B=3 -> after the edge Y=0, CO=0, V=0, VALID=0.
REQ-029 SHALL verify add: SnA=0, A=0x00000005, B=0x00000003 -> Y=0x00000008, CO=0, V=0, VALID=1; then A=0xFFFFFFFF, B=0x00000001 -> Y=0x00000000, CO=1, V=0.
REQ-030 SHALL verify subtract: SnA=1, A=5, B=3 -> Y=0x00000002, CO=1, V=0; then A=3, B=5 -> Y=0xFFFFFFFE, CO=0, V=0.
REQ-031 SHALL verify overflow: SnA=0, A=0x7FFFFFFF, B=1 -> Y=0x80000000, V=1, CO=0; then SnA=1, A=0x80000000, B=1 -> Y=0x7FFFFFFF, V=1, CO=1.
REQ-032 SHALL verify hold: after a result of 8, set EN=0 with A=9, B=9 for 3 cycles -> Y stays 0x00000008 and VALID=0.
REQ-033 SHALL verify random compare: 10,000 random A, B, SnA, EN -> Y, CO and V match the 33-bit arithmetic model on every cycle.
